// File: rtl/bp_pkg.sv
// Shared constants and helpers for the fetch-stage branch predictor.
// Mode encodings and the weak-taken / weak-not-taken counter seeds.
package bp_pkg;

   localparam int MODE_STATIC  = 0;
   localparam int MODE_BIMODAL = 1;
   localparam int MODE_GSHARE  = 2;

   function automatic int weak_t(input int cnt_w);
      return 1 << (cnt_w - 1);
   endfunction

   function automatic int weak_nt(input int cnt_w);
      return (1 << (cnt_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next-value saturating up/down counter used on the
// predictor update path; sticks at all-zeros and all-ones.
module bp_sat_ctr #(
   parameter int CNT_W = 2
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             up,
   output logic [CNT_W-1:0] cnt_nxt
);

   always_comb begin
      cnt_nxt = cnt;
      if (up) begin
         if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + CNT_W'(1);
      end else begin
         if (cnt != {CNT_W{1'b0}}) cnt_nxt = cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/syn_branch_predictor.sv
// Tagged direct-mapped branch predictor for the fetch stage: static,
// bimodal or gshare lookup, resolution-time update, quality statistics.
module syn_branch_predictor
   import bp_pkg::*;
#(
   parameter int PC_W  = 10,
   parameter int IDX_W = 4,
   parameter int TAG_W = 4,
   parameter int CNT_W = 2,
   parameter int MODE  = 1,
   parameter int GHR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [PC_W-1:0]  lkp_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [PC_W-1:0]  pc_guessed,
   input  logic             upd_en,
   input  logic [PC_W-1:0]  upd_pc,
   input  logic             upd_taken,
   input  logic [PC_W-1:0]  upd_target,
   input  logic             upd_mispred,
   output logic [GHR_W-1:0] ghr,
   output logic [31:0]      stat_updates,
   output logic [31:0]      stat_mispreds
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(weak_t(CNT_W));
   localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(weak_nt(CNT_W));

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic             tbl_vld [ENTRIES];
   logic [CNT_W-1:0] tbl_cnt [ENTRIES];
   logic [TAG_W-1:0] tbl_tag [ENTRIES];
   logic [PC_W-1:0]  tbl_tgt [ENTRIES];

   logic [GHR_W-1:0] ghr_q;
   logic [31:0]      stat_upd_q;
   logic [31:0]      stat_mis_q;

   // History only folds into the index in gshare mode.
   logic [IDX_W-1:0] ghr_idx;
   assign ghr_idx = (MODE == MODE_GSHARE) ? IDX_W'(ghr_q) : '0;

   // Lookup: combinational off the fetch PC.
   logic [IDX_W-1:0] lkp_idx;
   logic [TAG_W-1:0] lkp_tag;
   assign lkp_idx = lkp_pc[IDX_W-1:0] ^ ghr_idx;
   assign lkp_tag = lkp_pc[IDX_W+TAG_W-1:IDX_W];

   assign pred_hit   = tbl_vld[lkp_idx] && (tbl_tag[lkp_idx] == lkp_tag);
   assign pred_taken = (MODE != MODE_STATIC) && pred_hit && tbl_cnt[lkp_idx][CNT_W-1];
   assign pc_guessed = pred_taken ? tbl_tgt[lkp_idx] : lkp_pc + PC_W'(1);

   // Update: index from the pre-shift history, one counter step per branch.
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic [CNT_W-1:0] cnt_step;
   logic             do_flush;
   logic             accept;
   logic             tbl_wr;
   logic             unused_upd_pc;

   assign upd_idx       = upd_pc[IDX_W-1:0] ^ ghr_idx;
   assign upd_tag       = upd_pc[IDX_W+TAG_W-1:IDX_W];
   assign upd_hit       = tbl_vld[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
   assign do_flush      = en && flush;
   assign accept        = en && upd_en && !flush;
   assign tbl_wr        = accept && (MODE != MODE_STATIC) && (upd_hit || upd_taken);
   assign unused_upd_pc = ^upd_pc;

   bp_sat_ctr #(
      .CNT_W (CNT_W)
   ) u_upd_ctr (
      .cnt     (tbl_cnt[upd_idx]),
      .up      (upd_taken),
      .cnt_nxt (cnt_step)
   );

   // Control state: valid bits, counters, history, statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_vld[i] <= 1'b0;
            tbl_cnt[i] <= WEAK_NT;
         end
         ghr_q      <= '0;
         stat_upd_q <= '0;
         stat_mis_q <= '0;
      end else if (do_flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_vld[i] <= 1'b0;
            tbl_cnt[i] <= WEAK_NT;
         end
         ghr_q <= '0;
      end else if (accept) begin
         stat_upd_q <= sat_inc32(stat_upd_q);
         if (upd_mispred) stat_mis_q <= sat_inc32(stat_mis_q);
         if (tbl_wr) begin
            tbl_vld[upd_idx] <= 1'b1;
            tbl_cnt[upd_idx] <= upd_hit ? cnt_step : WEAK_T;
         end
         if (MODE == MODE_GSHARE) ghr_q <= GHR_W'({ghr_q, upd_taken});
      end
   end

   // Tag/target payload carries no reset; the valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (tbl_wr && upd_taken) begin
         tbl_tag[upd_idx] <= upd_tag;
         tbl_tgt[upd_idx] <= upd_target;
      end
   end

   assign ghr           = ghr_q;
   assign stat_updates  = stat_upd_q;
   assign stat_mispreds = stat_mis_q;

endmodule

// File: doc/syn_branch_predictor.md
# syn_branch_predictor

Parametrised branch target/history predictor for the fetch (ps0) stage of the pipelined core. It replaces the fixed `pc_guessed = pc_4` guess with a tagged, direct-mapped table of saturating counters and targets, selectable as static, bimodal or gshare. Lookup is combinational off the fetch PC. Update happens at branch resolution (ps3), driven by the WTG result. Two saturating statistics counters expose prediction quality on the debug path.

## Interface
Parameters:
- `PC_W`, 10: word-address width; matches `IM_ADDR_BIT`.
- `IDX_W`, 4: log2 of table entries.
- `TAG_W`, 4: tag bits. Range 1..`PC_W-IDX_W`.
- `CNT_W`, 2: saturating counter width, ≥1.
- `MODE`, 1: 0 = static not-taken, 1 = bimodal, 2 = gshare.
- `GHR_W`, 4: global history width. Used only in gshare mode, ≤`IDX_W`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global enable. No state changes while low.
- `flush` in 1: synchronous table invalidate.
- `lkp_pc` in `PC_W`: fetch word address.
- `pred_hit` out 1: valid entry with matching tag.
- `pred_taken` out 1: predicted taken.
- `pc_guessed` out `PC_W`: next fetch address.
- `upd_en` in 1: a branch or jump resolves this cycle.
- `upd_pc` in `PC_W`: resolving instruction address.
- `upd_taken` in 1: actual outcome.
- `upd_target` in `PC_W`: actual taken target.
- `upd_mispred` in 1: pipeline's `!pred_succ` for this instruction.
- `ghr` out `GHR_W`: global history. Always 0 unless `MODE`=2.
- `stat_updates` out 32: accepted updates.
- `stat_mispreds` out 32: accepted updates with `upd_mispred`=1.

## Operation
- **Index and tag.** In gshare mode, index = `pc[IDX_W-1:0]` XOR `ghr` (zero-extended). Otherwise index = `pc[IDX_W-1:0]`. Tag = `pc[IDX_W+TAG_W-1:IDX_W]`.
- **Entry contents.** Each entry holds `valid`, `tag`, `cnt[CNT_W]` and `target[PC_W]`.
- **Lookup (combinational).**
  - `pred_hit` = valid && tag match.
  - `pred_taken` = `pred_hit` && `cnt` MSB. Forced to 0 in `MODE`=0.
  - `pc_guessed` = `pred_taken` ? `target` : `lkp_pc+1`, modulo 2^`PC_W`.
- **Update** (accepted when `en && upd_en && !flush`):
  - Hit and taken: `cnt` saturating +1; `target` ← `upd_target`.
  - Hit and not taken: `cnt` saturating −1.
  - Miss and taken: allocate. Set valid, write tag, `target` ← `upd_target`, `cnt` ← `WEAK_T` = 2^(`CNT_W`−1).
  - Miss and not taken: no table write.
  - gshare only: `ghr` ← {`ghr[GHR_W-2:0]`, `upd_taken`}. The index uses the GHR value from before the shift.
  - `stat_updates` +1. `stat_mispreds` +1 if `upd_mispred`. Both saturate at 0xFFFF_FFFF.
  - `MODE`=0: the table and `ghr` are never written. Statistics still count.
- **Flush** (`en && flush`):
  - All valid bits cleared, `ghr` ← 0, counters ← `WEAK_NT` = 2^(`CNT_W`−1)−1.
  - Statistics are retained.
  - Any same-cycle update is dropped entirely, including its statistics.
- **Disabled.** With `en`=0, flush and update are both ignored.

## Timing
- **Reset.** Asynchronous assert clears all valid bits, counters to `WEAK_NT`, `ghr` 0, both statistics 0. Immediately after reset: `pred_hit`=0, `pred_taken`=0, `pc_guessed`=`lkp_pc+1`.
- **Lookup latency.** Zero cycles: lookup is combinational from `lkp_pc` and current state.
- **Update latency.** Takes effect at the accepting posedge and is visible to lookups from the next cycle. A same-cycle lookup of the same entry sees the pre-update contents (no bypass).
- **Reset during operation.** An in-flight update is lost. There is no partial write.

## Structure
- **Package `bp_pkg`.** Holds the `MODE_STATIC`/`MODE_BIMODAL`/`MODE_GSHARE` constants and the functions `weak_t(CNT_W)` and `weak_nt(CNT_W)`.
- **Sub-module `bp_sat_ctr`.** Combinational next-value saturating up/down counter, parametrised on width. It is instantiated once for the update path.
- **Storage.** Flop arrays, not RAM. Lookup needs an asynchronous read.

## Test plan
- **Reset.** Assert `rst`, `lkp_pc`=0x010 → `pred_hit`=0, `pc_guessed`=0x011, both statistics 0.
- **Bimodal train and saturation** (`CNT_W`=2).
  - Update `upd_pc`=0x020, taken, target 0x008 → next cycle lookup 0x020 gives hit, taken, `pc_guessed`=0x008.
  - Two not-taken updates → counter 2→1→0, `pc_guessed`=0x021.
  - Third not-taken update → counter stays 0.
  - Four taken updates → counter stays 3.
- **Aliasing** (`IDX_W`=4). Allocate at 0x005, then look up 0x015 → `pred_hit`=0, `pc_guessed`=0x016.
- **Flush priority and enable.**
  - `flush`+`upd_en` in the same cycle → entry invalid, `stat_updates` unchanged.
  - `en`=0 with `upd_en`=1 → no state change.
- **Gshare.** Three taken updates → `ghr`=0b0111. The next update at `upd_pc`=0x030 writes index 0x7. Lookup 0x030 with the same `ghr` hits.
- **Wrap and statistics.**
  - `lkp_pc`=0x3FF on a miss → `pc_guessed`=0x000.
  - Five updates, two with `upd_mispred` → `stat_updates`=5, `stat_mispreds`=2.
